// File: rtl/fp_addsub_pipe.sv
// -----------------------------------------------------------------------------
// fp_addsub_pipe
//
// Three-stage pipelined IEEE-754 adder/subtractor with valid/ready flow
// control, round-to-nearest-even and canonical special-value handling.
// Denormal operands are flushed to signed zero, and tiny results are flushed
// to signed zero as well.
//
//   S1  unpack, classify, swap larger magnitude first, align smaller operand
//   S2  significand add / subtract
//   S3  normalise, round, pack (this register drives the outputs)
//
// Optional build macro:
//   FP_ADDSUB_FLAGS_EN  adds the out_flags port and all flag logic.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, empties the pipeline
//   in_valid   operand pair present on a/b/symbol
//   in_ready   block accepts operands this cycle
//   a, b       operands, DATA_WIDTH bits each
//   symbol     0 = a+b, 1 = a-b
//   out_valid  result present on out
//   out_ready  downstream accepts result
//   out        result, DATA_WIDTH bits
//   out_flags  {invalid, overflow, underflow, inexact} (FP_ADDSUB_FLAGS_EN only)
// -----------------------------------------------------------------------------
module fp_addsub_pipe #(
   parameter int EXP_W      = 8,
   parameter int MAN_W      = 23,
   // Derived from the field widths; leave at its default.
   parameter int DATA_WIDTH = 1 + EXP_W + MAN_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  symbol,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out
`ifdef FP_ADDSUB_FLAGS_EN
   ,
   output logic [3:0]            out_flags
`endif
);

   // Working significand: hidden bit, stored mantissa, guard, round, sticky.
   localparam int SW  = MAN_W + 4;
   localparam int LZW = $clog2(SW + 1);

   localparam logic [EXP_W-1:0]      EXP_ONES = {EXP_W{1'b1}};
   localparam logic [DATA_WIDTH-1:0] QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   // ---------------------------------------------------------------------------
   // Flow control
   // ---------------------------------------------------------------------------
   logic s1_valid, s2_valid, s3_valid;
   logic s3_ready, s2_ready, s1_advance;

   assign s3_ready   = !s3_valid || out_ready;
   assign s2_ready   = !s2_valid || s3_ready;
   assign s1_advance = s1_valid && s2_ready;
   assign in_ready   = !s1_valid || s1_advance;
   assign out_valid  = s3_valid;

   // ---------------------------------------------------------------------------
   // S1: unpack, classify, swap, align
   // ---------------------------------------------------------------------------
   logic             a_sign, b_sign;
   logic [EXP_W-1:0] a_exp, b_exp;
   logic [MAN_W-1:0] a_man, b_man;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   assign a_sign = a[DATA_WIDTH-1];
   assign b_sign = b[DATA_WIDTH-1] ^ symbol;
   assign a_exp  = a[DATA_WIDTH-2 -: EXP_W];
   assign b_exp  = b[DATA_WIDTH-2 -: EXP_W];
   assign a_man  = a[MAN_W-1:0];
   assign b_man  = b[MAN_W-1:0];

   // A zero exponent covers both true zeros and denormals (flushed).
   assign a_zero = (a_exp == '0);
   assign b_zero = (b_exp == '0);
   assign a_inf  = (a_exp == EXP_ONES) && (a_man == '0);
   assign b_inf  = (b_exp == EXP_ONES) && (b_man == '0);
   assign a_nan  = (a_exp == EXP_ONES) && (a_man != '0);
   assign b_nan  = (b_exp == EXP_ONES) && (b_man != '0);

   logic                  c1_special;
   logic [DATA_WIDTH-1:0] c1_spec_val;

   // NOTE: every always_comb output gets a default on its first line, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      c1_special  = 1'b1;
      c1_spec_val = QNAN;
      if (a_nan || b_nan) begin
         c1_spec_val = QNAN;
      end else if (a_inf && b_inf && (a_sign != b_sign)) begin
         c1_spec_val = QNAN;
      end else if (a_inf) begin
         c1_spec_val = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
      end else if (b_inf) begin
         c1_spec_val = {b_sign, EXP_ONES, {MAN_W{1'b0}}};
      end else if (a_zero && b_zero) begin
         // Only (-0)+(-0) keeps the negative sign under round-to-nearest.
         c1_spec_val = {a_sign & b_sign, {(DATA_WIDTH-1){1'b0}}};
      end else if (b_zero) begin
         c1_spec_val = a;
      end else if (a_zero) begin
         c1_spec_val = {b_sign, b[DATA_WIDTH-2:0]};
      end else begin
         c1_special = 1'b0;
      end
   end

`ifdef FP_ADDSUB_FLAGS_EN
   logic a_snan, b_snan, c1_invalid;
   assign a_snan     = a_nan && !a_man[MAN_W-1];
   assign b_snan     = b_nan && !b_man[MAN_W-1];
   assign c1_invalid = (a_nan || b_nan) ? (a_snan || b_snan)
                                        : (a_inf && b_inf && (a_sign != b_sign));
`endif

   // Exponent and mantissa concatenated compare as an unsigned magnitude.
   logic             b_bigger;
   logic             big_sign;
   logic [EXP_W-1:0] big_exp, small_exp, exp_diff;
   logic [MAN_W-1:0] big_man, small_man;
   logic [SW-1:0]    small_ext, lost_mask, aligned;

   assign b_bigger  = {b_exp, b_man} > {a_exp, a_man};
   assign big_sign  = b_bigger ? b_sign : a_sign;
   assign big_exp   = b_bigger ? b_exp  : a_exp;
   assign big_man   = b_bigger ? b_man  : a_man;
   assign small_exp = b_bigger ? a_exp  : b_exp;
   assign small_man = b_bigger ? a_man  : b_man;
   assign exp_diff  = big_exp - small_exp;
   assign small_ext = {1'b1, small_man, 3'b000};

   // Bits shifted past the sticky position are OR-ed back into it. Once the
   // shift reaches the full width, only the sticky bit survives.
   always_comb begin
      lost_mask = '0;
      aligned   = {{(SW-1){1'b0}}, 1'b1};
      if (32'(exp_diff) < SW) begin
         lost_mask = ~({SW{1'b1}} << exp_diff);
         aligned   = (small_ext >> exp_diff) |
                     {{(SW-1){1'b0}}, |(small_ext & lost_mask)};
      end
   end

   logic                  s1_sign, s1_sub, s1_special;
   logic [EXP_W-1:0]      s1_exp;
   logic [SW-1:0]         s1_big, s1_small;
   logic [DATA_WIDTH-1:0] s1_spec_val;

   // ---------------------------------------------------------------------------
   // S2: significand add / subtract (larger magnitude is always s1_big)
   // ---------------------------------------------------------------------------
   logic [SW:0] c2_sum;
   assign c2_sum = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                          : ({1'b0, s1_big} + {1'b0, s1_small});

   logic                  s2_sign, s2_special;
   logic [EXP_W-1:0]      s2_exp;
   logic [SW:0]           s2_sum;
   logic [DATA_WIDTH-1:0] s2_spec_val;

`ifdef FP_ADDSUB_FLAGS_EN
   logic s1_invalid, s2_invalid;
`endif

   // ---------------------------------------------------------------------------
   // S3: normalise, round to nearest even, pack
   // ---------------------------------------------------------------------------
   logic [LZW-1:0]        lz;
   logic [SW-1:0]         norm;
   logic [EXP_W+1:0]      exp_n, exp_r;
   logic [MAN_W+1:0]      rounded;
   logic [MAN_W-1:0]      res_man;
   logic                  guard, rnd_sticky, round_up;
   logic                  is_uf, is_of;
   logic [DATA_WIDTH-1:0] c3_res;

   always_comb begin
      // Leading-zero count of the carry-free sum; the highest set bit wins.
      lz = LZW'(SW);
      for (int i = 0; i < SW; i++) begin
         if (s2_sum[i]) lz = LZW'(SW - 1 - i);
      end

      norm  = s2_sum[SW-1:0] << lz;
      exp_n = {2'b00, s2_exp} - (EXP_W+2)'(lz);
      if (s2_sum[SW]) begin
         norm  = {s2_sum[SW:2], s2_sum[1] | s2_sum[0]};
         exp_n = {2'b00, s2_exp} + (EXP_W+2)'(1);
      end

      guard      = norm[2];
      rnd_sticky = norm[1] | norm[0];
      round_up   = guard && (rnd_sticky || norm[3]);
      rounded    = {1'b0, norm[SW-1:3]} + (MAN_W+2)'(round_up);

      exp_r   = exp_n;
      res_man = rounded[MAN_W-1:0];
      if (rounded[MAN_W+1]) begin
         exp_r   = exp_n + (EXP_W+2)'(1);
         res_man = rounded[MAN_W:1];
      end
   end

   // exp_n is two's complement here; the top bit marks a negative exponent.
   assign is_uf = exp_n[EXP_W+1] || (exp_n == '0);
   assign is_of = (exp_r >= {2'b00, EXP_ONES});

   always_comb begin
      c3_res = {s2_sign, exp_r[EXP_W-1:0], res_man};
      if (s2_special) begin
         c3_res = s2_spec_val;
      end else if (s2_sum == '0) begin
         c3_res = '0;
      end else if (is_uf) begin
         c3_res = {s2_sign, {(DATA_WIDTH-1){1'b0}}};
      end else if (is_of) begin
         c3_res = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      end
   end

`ifdef FP_ADDSUB_FLAGS_EN
   logic [3:0] c3_flags;
   always_comb begin
      c3_flags = 4'b0000;
      if (s2_special) begin
         c3_flags[3] = s2_invalid;
      end else if (s2_sum != '0) begin
         c3_flags[0] = guard | rnd_sticky;
         if (is_uf) begin
            c3_flags[1:0] = 2'b11;
         end else if (is_of) begin
            c3_flags[2] = 1'b1;
            c3_flags[0] = 1'b1;
         end
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
         out      <= '0;
`ifdef FP_ADDSUB_FLAGS_EN
         out_flags <= 4'b0000;
`endif
      end else begin
         if (in_ready) s1_valid <= in_valid;
         if (s2_ready) s2_valid <= s1_valid;
         if (s3_ready) s3_valid <= s2_valid;
         if (s3_ready && s2_valid) begin
            out <= c3_res;
`ifdef FP_ADDSUB_FLAGS_EN
            out_flags <= c3_flags;
`endif
         end
      end
   end

   // NOTE: the S1/S2 payload registers carry no reset; they are only ever
   // observed behind their stage-valid bit, which reset does clear.
   always_ff @(posedge clk) begin
      if (in_ready && in_valid) begin
         s1_sign     <= big_sign;
         s1_sub      <= (a_sign != b_sign);
         s1_exp      <= big_exp;
         s1_big      <= {1'b1, big_man, 3'b000};
         s1_small    <= aligned;
         s1_special  <= c1_special;
         s1_spec_val <= c1_spec_val;
`ifdef FP_ADDSUB_FLAGS_EN
         s1_invalid  <= c1_invalid;
`endif
      end
      if (s1_advance) begin
         s2_sign     <= s1_sign;
         s2_exp      <= s1_exp;
         s2_sum      <= c2_sum;
         s2_special  <= s1_special;
         s2_spec_val <= s1_spec_val;
`ifdef FP_ADDSUB_FLAGS_EN
         s2_invalid  <= s1_invalid;
`endif
      end
   end

endmodule
